// File: rtl/exec_pipeline.sv
// exec_pipeline: parametrised execute pipeline wrapped around the combinational alu.
//
// The alu result plus all rename tags (ROB entry, dest/flag physical regs,
// arch dest mask) enter stage 0 on accept and march through STAGES register
// stages to writeback. Valid/ready back-pressure collapses bubbles: any empty
// stage keeps its upstream neighbour moving even when writeback is stalled.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   issue handshake (in_ready never depends on in_valid)
//   opcode, op_a_val, op_b_val, flags_val   alu operands
//   rob_entry, dest_reg, flag_reg, arch_dest_regs   tags carried alongside
//   flush                 kills everything in flight and the same-cycle input
//   out_valid / out_ready writeback handshake
//   *_out, result_val, result_flags   driven straight from the last stage
//
// Optional build macro EXEC_PIPE_PERF_EN adds saturating 16-bit counters
// perf_issued (accepted instructions) and perf_stall (cycles with
// in_valid && !in_ready). They clear on rst only.

// Combinational ALU.
//   f_out = {f_in[7:4], overflow, negative, zero, carry}
//   0 ADD, 1 ADC (carry in = f_in[0]), 2 SUB (carry = borrow), 3 AND, 4 OR,
//   5 XOR, 6 SHL by b[2:0], 7 SHR by b[2:0], 8 NOT a, 9 PASS b, others PASS a
module alu (
  input  logic [3:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] f_in,
  output logic [7:0] q,
  output logic [7:0] f_out
);
  logic [8:0] wide;
  logic       c;
  logic       ov;

  always_comb begin
    wide = '0;
    q    = a;
    c    = 1'b0;
    ov   = 1'b0;
    case (opcode)
      4'h0: begin
        wide = {1'b0, a} + {1'b0, b};
        q    = wide[7:0];
        c    = wide[8];
        ov   = (a[7] == b[7]) && (q[7] != a[7]);
      end
      4'h1: begin
        wide = {1'b0, a} + {1'b0, b} + {8'd0, f_in[0]};
        q    = wide[7:0];
        c    = wide[8];
        ov   = (a[7] == b[7]) && (q[7] != a[7]);
      end
      4'h2: begin
        // Bit 8 of the 9-bit difference is the borrow.
        wide = {1'b0, a} - {1'b0, b};
        q    = wide[7:0];
        c    = wide[8];
        ov   = (a[7] != b[7]) && (q[7] != a[7]);
      end
      4'h3: q = a & b;
      4'h4: q = a | b;
      4'h5: q = a ^ b;
      4'h6: q = a << b[2:0];
      4'h7: q = a >> b[2:0];
      4'h8: q = ~a;
      4'h9: q = b;
      default: q = a;
    endcase
    f_out = {f_in[7:4], ov, q[7], (q == 8'd0), c};
  end
endmodule

module exec_pipeline #(
  parameter int STAGES = 2,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 5,
  parameter int ARCH_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [ROB_W-1:0]  rob_entry,
  input  logic [PREG_W-1:0] dest_reg,
  input  logic [PREG_W-1:0] flag_reg,
  input  logic [7:0]        op_a_val,
  input  logic [7:0]        op_b_val,
  input  logic [7:0]        flags_val,
  input  logic [ARCH_W-1:0] arch_dest_regs,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROB_W-1:0]  rob_entry_out,
  output logic [PREG_W-1:0] dest_reg_out,
  output logic [PREG_W-1:0] flag_reg_out,
  output logic [7:0]        result_val,
  output logic [7:0]        result_flags,
  output logic [ARCH_W-1:0] arch_dest_regs_out
`ifdef EXEC_PIPE_PERF_EN
  ,
  output logic [15:0]       perf_issued,
  output logic [15:0]       perf_stall
`endif
);

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] dest;
    logic [PREG_W-1:0] flag;
    logic [7:0]        q;
    logic [7:0]        f;
    logic [ARCH_W-1:0] arch;
  } payload_t;

  logic [7:0]        alu_q;
  logic [7:0]        alu_f;
  logic [STAGES-1:0] v_reg;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_v;
  payload_t          pay_reg [STAGES];
  payload_t          src_p   [STAGES];
  logic              accept;

  alu u_alu (
    .opcode (opcode),
    .a      (op_a_val),
    .b      (op_b_val),
    .f_in   (flags_val),
    .q      (alu_q),
    .f_out  (alu_f)
  );

  // Advance chain, walked from writeback back to stage 0. A running term
  // keeps each stage's enable as "self empty, or everything below moves",
  // which is what lets a bubble anywhere pull the upstream stages forward.
  always_comb begin
    logic chain;
    chain = out_ready;
    adv   = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain  = !v_reg[i] || chain;
      adv[i] = chain;
    end
  end

  assign in_ready = adv[0];
  assign accept   = in_valid && in_ready && !flush;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_src_in
      assign src_v[gi] = accept;
      assign src_p[gi] = '{rob: rob_entry, dest: dest_reg, flag: flag_reg,
                           q: alu_q, f: alu_f, arch: arch_dest_regs};
    end else begin : g_src_prev
      assign src_v[gi] = v_reg[gi-1];
      assign src_p[gi] = pay_reg[gi-1];
    end

    // Payload only loads when a real instruction arrives, so after reset
    // the outputs stay at zero until the first result reaches the end.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_reg[gi]   <= 1'b0;
        pay_reg[gi] <= '0;
      end else if (flush) begin
        v_reg[gi] <= 1'b0;
      end else if (adv[gi]) begin
        v_reg[gi] <= src_v[gi];
        if (src_v[gi]) begin
          pay_reg[gi] <= src_p[gi];
        end
      end
    end
  end

  assign out_valid          = v_reg[STAGES-1];
  assign rob_entry_out      = pay_reg[STAGES-1].rob;
  assign dest_reg_out       = pay_reg[STAGES-1].dest;
  assign flag_reg_out       = pay_reg[STAGES-1].flag;
  assign result_val         = pay_reg[STAGES-1].q;
  assign result_flags       = pay_reg[STAGES-1].f;
  assign arch_dest_regs_out = pay_reg[STAGES-1].arch;

`ifdef EXEC_PIPE_PERF_EN
  logic [15:0] perf_issued_reg;
  logic [15:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_reg <= '0;
      perf_stall_reg  <= '0;
    end else begin
      if (accept && (perf_issued_reg != 16'hFFFF)) begin
        perf_issued_reg <= perf_issued_reg + 16'd1;
      end
      if (in_valid && !in_ready && (perf_stall_reg != 16'hFFFF)) begin
        perf_stall_reg <= perf_stall_reg + 16'd1;
      end
    end
  end

  assign perf_issued = perf_issued_reg;
  assign perf_stall  = perf_stall_reg;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_exec_pipeline.sv
// Randomised + directed bench for exec_pipeline. The reference keeps the
// in-flight instructions as a queue with a "distance travelled" per entry
// and derives handshakes from occupancy, computing alu results arithmetically.
module tb_exec_pipeline;
  localparam int STAGES = 2;
  localparam int ROB_W  = 5;
  localparam int PREG_W = 5;
  localparam int ARCH_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode;
  logic [ROB_W-1:0]  rob_entry;
  logic [PREG_W-1:0] dest_reg;
  logic [PREG_W-1:0] flag_reg;
  logic [7:0]        op_a_val;
  logic [7:0]        op_b_val;
  logic [7:0]        flags_val;
  logic [ARCH_W-1:0] arch_dest_regs;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ROB_W-1:0]  rob_entry_out;
  logic [PREG_W-1:0] dest_reg_out;
  logic [PREG_W-1:0] flag_reg_out;
  logic [7:0]        result_val;
  logic [7:0]        result_flags;
  logic [ARCH_W-1:0] arch_dest_regs_out;
`ifdef EXEC_PIPE_PERF_EN
  logic [15:0]       perf_issued;
  logic [15:0]       perf_stall;
`endif

  exec_pipeline #(.STAGES(STAGES), .ROB_W(ROB_W), .PREG_W(PREG_W), .ARCH_W(ARCH_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .opcode             (opcode),
    .rob_entry          (rob_entry),
    .dest_reg           (dest_reg),
    .flag_reg           (flag_reg),
    .op_a_val           (op_a_val),
    .op_b_val           (op_b_val),
    .flags_val          (flags_val),
    .arch_dest_regs     (arch_dest_regs),
    .flush              (flush),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .rob_entry_out      (rob_entry_out),
    .dest_reg_out       (dest_reg_out),
    .flag_reg_out       (flag_reg_out),
    .result_val         (result_val),
    .result_flags       (result_flags),
    .arch_dest_regs_out (arch_dest_regs_out)
`ifdef EXEC_PIPE_PERF_EN
    ,
    .perf_issued        (perf_issued),
    .perf_stall         (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] dest;
    logic [PREG_W-1:0] flag;
    logic [7:0]        q;
    logic [7:0]        f;
    logic [ARCH_W-1:0] arch;
    int                pos;
  } item_t;

  item_t mq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    m_issued = 0;
  int    m_stall = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference alu: {flags, result} from plain integer arithmetic.
  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] fi);
    int ua, ub, sa, sb, r, s;
    logic c, ov;
    logic [7:0] q;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c = 1'b0; ov = 1'b0;
    case (op)
      4'h0: begin r = ua + ub; c = (r > 255); s = sa + sb; ov = (s > 127) || (s < -128); end
      4'h1: begin r = ua + ub + int'(fi[0]); c = (r > 255);
                  s = sa + sb + int'(fi[0]); ov = (s > 127) || (s < -128); end
      4'h2: begin r = ua - ub; c = (ua < ub); s = sa - sb; ov = (s > 127) || (s < -128); end
      4'h3: r = ua & ub;
      4'h4: r = ua | ub;
      4'h5: r = ua ^ ub;
      4'h6: r = ua * (1 << (ub % 8));
      4'h7: r = ua / (1 << (ub % 8));
      4'h8: r = 255 - ua;
      4'h9: r = ub;
      default: r = ua;
    endcase
    q = 8'(r & 255);
    return {fi[7:4], ov, (q >= 8'd128), (q == 8'd0), c, q};
  endfunction

  // One clock: compare at the falling edge, then advance the reference.
  task automatic cycle();
    logic  m_ready, m_valid, consumed, accept, moved, prev_moved;
    int    prev_pos, old;
    item_t it;
    logic [15:0] fq;
    @(negedge clk);
    m_ready = out_ready || (mq.size() < STAGES);
    m_valid = (mq.size() > 0) && (mq[0].pos == STAGES - 1);
    check("in_ready", 64'(in_ready), 64'(m_ready));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("rob_out", 64'(rob_entry_out), 64'(mq[0].rob));
      check("dest_out", 64'(dest_reg_out), 64'(mq[0].dest));
      check("flag_out", 64'(flag_reg_out), 64'(mq[0].flag));
      check("result_val", 64'(result_val), 64'(mq[0].q));
      check("result_flags", 64'(result_flags), 64'(mq[0].f));
      check("arch_out", 64'(arch_dest_regs_out), 64'(mq[0].arch));
    end
`ifdef EXEC_PIPE_PERF_EN
    check("perf_issued", 64'(perf_issued), 64'(m_issued));
    check("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
    if (rst) begin
      mq.delete();
      m_issued = 0;
      m_stall = 0;
    end else begin
      consumed = m_valid && out_ready;
      accept   = in_valid && m_ready && !flush;
      if (accept && m_issued < 65535) m_issued++;
      if (in_valid && !m_ready && m_stall < 65535) m_stall++;
      if (consumed)
        $display("retire rob=%0d dest=%0d q=%02h f=%02h", mq[0].rob, mq[0].dest, mq[0].q, mq[0].f);
      if (flush) begin
        mq.delete();
      end else begin
        // Each entry moves one step when the slot ahead is free or its
        // predecessor is moving; the head leaves only when consumed.
        prev_moved = consumed;
        prev_pos   = STAGES;
        for (int k = 0; k < mq.size(); k++) begin
          old = mq[k].pos;
          if (k == 0) moved = (old < STAGES - 1) || consumed;
          else        moved = (old + 1 < prev_pos) || prev_moved;
          if (moved && old < STAGES - 1) mq[k].pos = old + 1;
          prev_pos   = old;
          prev_moved = moved;
        end
        if (consumed) void'(mq.pop_front());
        if (accept) begin
          fq = alu_ref(opcode, op_a_val, op_b_val, flags_val);
          it.rob = rob_entry; it.dest = dest_reg; it.flag = flag_reg;
          it.q = fq[7:0]; it.f = fq[15:8]; it.arch = arch_dest_regs; it.pos = 0;
          mq.push_back(it);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload();
    opcode         = 4'($urandom_range(0, 11));
    rob_entry      = ROB_W'($urandom);
    dest_reg       = PREG_W'($urandom);
    flag_reg       = PREG_W'($urandom);
    op_a_val       = 8'($urandom);
    op_b_val       = 8'($urandom);
    flags_val      = 8'($urandom);
    arch_dest_regs = ARCH_W'($urandom);
  endtask

  initial begin
    int snap;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rand_payload();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency: ADD 5+3 appears exactly STAGES cycles after accept.
    out_ready = 1'b1; in_valid = 1'b1; opcode = 4'h0; op_a_val = 8'h05; op_b_val = 8'h03;
    rob_entry = 5'd7; dest_reg = 5'd12; flags_val = 8'h00;
    cycle();
    in_valid = 1'b0;
    check("lat_early", 64'(out_valid), 64'd0);
    cycle();
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_result", 64'(result_val), 64'h08);
    check("lat_rob", 64'(rob_entry_out), 64'd7);
    check("lat_dest", 64'(dest_reg_out), 64'd12);
    check("lat_flags", 64'(result_flags), 64'h00);
    repeat (2) cycle();

    // Back-to-back streaming of 10.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_payload(); in_valid = 1'b1; cycle();
    end
    in_valid = 1'b0;
    repeat (STAGES + 2) cycle();

    // Back-pressure: issue for 5 cycles with writeback stalled, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_payload(); in_valid = 1'b1; cycle();
    end
    check("bp_full", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (STAGES + 3) cycle();

    // Bubble collapse: one instruction parked in the last stage.
    out_ready = 1'b0;
    rand_payload(); in_valid = 1'b1; cycle();
    in_valid = 1'b0;
    repeat (STAGES - 1) cycle();
    rand_payload(); in_valid = 1'b1;
    check("bubble_ready", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (STAGES + 2) cycle();

    // Flush with 2 in flight and a valid input on the flush cycle.
    snap = m_issued;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_payload(); in_valid = 1'b1; cycle();
    end
    rand_payload(); in_valid = 1'b1; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("flush_quiet", 64'(out_valid), 64'd0);
      cycle();
    end
`ifdef EXEC_PIPE_PERF_EN
    check("flush_issued", 64'(perf_issued), 64'(snap + 2));
`endif

    // Reset with the pipeline full.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) begin
      rand_payload(); in_valid = 1'b1; cycle();
    end
    in_valid = 1'b0; rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'({rob_entry_out, dest_reg_out, flag_reg_out, result_val,
                           result_flags, arch_dest_regs_out}), 64'd0);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 2000; i++) begin
      rand_payload();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (STAGES + 2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exec_pipeline.md
Name: exec_pipeline

Overview:
- Parametrised successor to the single-stage arithmetic pipeline.
- Wraps the existing combinational `alu` (opcode, a, b, f_in -> q, f_out).
- Carries results and rename tags (ROB entry, dest/flag physical regs, arch dest mask) through STAGES register stages to writeback.
- Adds valid/ready back-pressure with bubble collapsing, a full flush for mispredict recovery, and synchronous reset.

Parameters:
- STAGES, 2, number of register stages after the ALU (1..8); latency in cycles with no stall.
- ROB_W, 5, ROB entry index width.
- PREG_W, 5, physical register tag width (dest and flag).
- ARCH_W, 8, arch-destination mask width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  issue slot holds an instruction.
- in_ready  out  1  pipeline accepts this cycle.
- opcode  in  4  ALU opcode.
- rob_entry  in  ROB_W  ROB index.
- dest_reg  in  PREG_W  physical dest tag.
- flag_reg  in  PREG_W  physical flags tag.
- op_a_val  in  8  operand A.
- op_b_val  in  8  operand B.
- flags_val  in  8  input flags.
- arch_dest_regs  in  ARCH_W  arch dest mask.
- flush  in  1  kill all in-flight and same-cycle input.
- out_valid  out  1  last stage holds a result.
- out_ready  in  1  writeback consumes this cycle.
- rob_entry_out  out  ROB_W  tag passthrough.
- dest_reg_out  out  PREG_W  tag passthrough.
- flag_reg_out  out  PREG_W  tag passthrough.
- result_val  out  8  ALU result.
- result_flags  out  8  ALU flags.
- arch_dest_regs_out  out  ARCH_W  mask passthrough.

Behaviour:
- ALU evaluated combinationally on input operands; stage 0 captures alu q/f_out plus all tags on accept (in_valid && in_ready && !flush).
- Per-stage registers: v[i] plus payload. Stage i loads from stage i-1 when stage i advances; payload is held otherwise.
- adv[STAGES-1] = !v[last] || out_ready.
- adv[i] = !v[i] || adv[i+1].
- in_ready = adv[0]; purely combinational, no dependence on in_valid.
- Outputs driven directly from the last stage registers; out_valid = v[last].
- Latency: accept at cycle N gives out_valid at cycle N+STAGES when no stall.
- Throughput: 1/cycle when out_ready held high.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Stall: with out_ready low and all stages full, in_ready = 0 and all payloads hold stable. out_valid never drops without a handshake or flush.
- Ordering: strict in-order; no reorder or duplication.
- flush: next cycle all v[i] = 0. The same-cycle input is discarded. A same-cycle out handshake still counts as consumed. Payload registers need not clear.
- rst: all v[i] = 0 and all payloads = 0 next edge, so every output reads 0 and in_ready = 1 after reset.
- rst mid-operation drops all in-flight work; rst has priority over flush.
- No unregistered paths from inputs to the data outputs.

Optional Feature:
- Macro: EXEC_PIPE_PERF_EN.
- Defined: adds outputs perf_issued [15:0] and perf_stall [15:0].
  - perf_issued increments on each accepted instruction.
  - perf_stall increments each cycle with in_valid && !in_ready.
  - Both saturate at 0xFFFF and clear on rst, not on flush.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset: assert rst 2 cycles with pipeline full -> next cycle out_valid = 0, all outputs 0, in_ready = 1.
- Latency, STAGES=2: add opcode, a=0x05, b=0x03, rob_entry=7, dest=12, out_ready=1 -> exactly 2 cycles later out_valid = 1, result_val = 0x08, rob_entry_out = 7, dest_reg_out = 12, flags match ALU model.
- Back-to-back streaming: 10 consecutive instructions, out_ready=1 -> 10 results on consecutive cycles, in order, tags intact.
- Back-pressure: out_ready=0 for 5 cycles while issuing 4 -> in_ready falls after STAGES accepts, outputs stable; release out_ready -> all results drain in order, none lost or duplicated.
- Bubble collapse: out_ready=0, one instruction in the last stage, stage 0 empty -> in_ready = 1 and a new instruction is accepted.
- Flush: 2 in flight plus a valid input on the flush cycle -> out_valid = 0 for the following cycles, no result ever emitted. With EXEC_PIPE_PERF_EN, perf_issued counts only the 2 accepted before flush.
